pipeline_run_ctrl: RTL and testbench

- Start/step controller that sits between the board switches and the pipeline processor.
- Synchronises and debounces the start and step switches.
- Selects free-run or single-step mode and drives the pipeline's global enable.
- Counts executed cycles and stops on a halt signal or a parametrised cycle limit, so benches no longer need multi-million-cycle start delays.

---
 rtl/pipeline_run_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_ctrl.sv
// Start/step controller between the board switches and the pipeline: debounces the
// switches, runs free or single-step, counts enabled cycles and stops on halt or limit.
module pipeline_run_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 32,
   parameter int MAX_CYCLES      = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             switchStart,
   input  logic             switchStep,
   input  logic             mode,
   input  logic             halt_in,
   output logic             en,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int               DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LIMIT_LAST = (MAX_CYCLES > 0) ? CNT_W'(MAX_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_STEP_WAIT,
      S_STEP_PULSE,
      S_HALTED
   } state_t;

   // Index 0 is the start switch, index 1 the step button.
   logic [1:0] w_raw;
   logic [1:0] w_db;
   logic [1:0] w_db_rise;
   logic [1:0] w_db_fall;

   assign w_raw = {switchStep, switchStart};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_switch
         logic            r_sync0;
         logic            r_sync1;
         logic            r_db;
         logic            r_db_q;
         logic [DB_W-1:0] r_db_cnt;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_sync0  <= 1'b0;
               r_sync1  <= 1'b0;
               r_db     <= 1'b0;
               r_db_q   <= 1'b0;
               r_db_cnt <= '0;
            end else begin
               r_sync0 <= w_raw[gi];
               r_sync1 <= r_sync0;
               r_db_q  <= r_db;
               // The level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
               if (r_sync1 != r_db) begin
                  if (r_db_cnt == DB_LAST) begin
                     r_db     <= r_sync1;
                     r_db_cnt <= '0;
                  end else begin
                     r_db_cnt <= r_db_cnt + 1'b1;
                  end
               end else begin
                  r_db_cnt <= '0;
               end
            end
         end

         assign w_db[gi]      = r_db;
         assign w_db_rise[gi] = r_db & ~r_db_q;
         assign w_db_fall[gi] = ~r_db & r_db_q;
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_next;
   logic             r_en;
   logic             r_running;
   logic             r_done;
   logic             r_timeout;
   logic             w_timeout_next;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;
   logic             w_limit;

   assign w_limit = (MAX_CYCLES > 0) && r_en && (r_count == LIMIT_LAST);

   always_comb begin
      w_state_next   = r_state;
      w_timeout_next = r_timeout;
      w_count_next   = r_count;
      if (r_en && (r_count != '1)) begin
         w_count_next = r_count + 1'b1;
      end
      case (r_state)
         S_IDLE: begin
            if (w_db_rise[0]) begin
               w_state_next = mode ? S_STEP_WAIT : S_RUN;
            end
         end
         S_RUN: begin
            if (halt_in) begin
               w_state_next = S_HALTED;
            end else if (w_limit) begin
               w_state_next   = S_HALTED;
               w_timeout_next = 1'b1;
            end else if (w_db_fall[0]) begin
               w_state_next = S_IDLE;
            end
         end
         S_STEP_WAIT: begin
            if (halt_in) begin
               w_state_next = S_HALTED;
            end else if (w_db_fall[0]) begin
               w_state_next = S_IDLE;
            end else if (w_db_rise[1]) begin
               w_state_next = S_STEP_PULSE;
            end
         end
         S_STEP_PULSE: begin
            if (halt_in) begin
               w_state_next = S_HALTED;
            end else if (w_limit) begin
               w_state_next   = S_HALTED;
               w_timeout_next = 1'b1;
            end else if (w_db_fall[0]) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_STEP_WAIT;
            end
         end
         S_HALTED: begin
            if (!w_db[0]) begin
               w_state_next   = S_IDLE;
               w_timeout_next = 1'b0;
               w_count_next   = '0;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_en      <= 1'b0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         r_count   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_en      <= (w_state_next == S_RUN) || (w_state_next == S_STEP_PULSE);
         r_running <= (w_state_next == S_RUN) || (w_state_next == S_STEP_WAIT) ||
                      (w_state_next == S_STEP_PULSE);
         r_done    <= (w_state_next == S_HALTED);
         r_timeout <= w_timeout_next;
         r_count   <= w_count_next;
      end
   end

   assign en          = r_en;
   assign running     = r_running;
   assign done        = r_done;
   assign timeout     = r_timeout;
   assign cycle_count = r_count;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: a limited instance and an unlimited narrow-counter instance
// share stimulus; both are compared each cycle against a behavioural model.
module tb_pipeline_run_ctrl;

   localparam int DBC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        switchStart = 1'b0;
   logic        switchStep = 1'b0;
   logic        mode = 1'b0;
   logic        halt_in = 1'b0;
   logic        en_a, running_a, done_a, timeout_a;
   logic [15:0] cnt_a;
   logic        en_b, running_b, done_b, timeout_b;
   logic [3:0]  cnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_run_ctrl #(.DEBOUNCE_CYCLES(DBC), .CNT_W(16), .MAX_CYCLES(20)) dut (
      .clk(clk), .rst(rst), .switchStart(switchStart), .switchStep(switchStep),
      .mode(mode), .halt_in(halt_in), .en(en_a), .running(running_a), .done(done_a),
      .timeout(timeout_a), .cycle_count(cnt_a)
   );

   pipeline_run_ctrl #(.DEBOUNCE_CYCLES(DBC), .CNT_W(4), .MAX_CYCLES(0)) dut_nl (
      .clk(clk), .rst(rst), .switchStart(switchStart), .switchStep(switchStep),
      .mode(mode), .halt_in(halt_in), .en(en_b), .running(running_b), .done(done_b),
      .timeout(timeout_b), .cycle_count(cnt_b)
   );

   // ---------------- behavioural model ----------------
   localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_PULSE = 3, M_HALT = 4;

   typedef struct packed {
      logic [1:0]      s1;
      logic [1:0]      s2;
      logic [1:0]      db;
      logic [1:0]      dbp;
      logic [1:0][7:0] run;
      int              st;
      longint          cnt;
      logic            to;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m    = '0;
      m.st = M_IDLE;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m_in, logic raw_start, logic raw_step, logic md,
                                     logic hl, int maxc, int cnt_w);
      mdl_t   m;
      logic   start_rise, start_fall, step_rise, en_now, at_limit;
      longint top;
      m          = m_in;
      top        = (longint'(1) << cnt_w) - 1;
      start_rise = m.db[0] & ~m.dbp[0];
      start_fall = ~m.db[0] & m.dbp[0];
      step_rise  = m.db[1] & ~m.dbp[1];
      en_now     = (m.st == M_RUN) || (m.st == M_PULSE);
      at_limit   = (maxc > 0) && en_now && (m.cnt == longint'(maxc) - 1);
      if (en_now && m.cnt < top) m.cnt = m.cnt + 1;
      case (m.st)
         M_IDLE:  if (start_rise) m.st = md ? M_WAIT : M_RUN;
         M_RUN: begin
            if (hl) m.st = M_HALT;
            else if (at_limit) begin m.st = M_HALT; m.to = 1'b1; end
            else if (start_fall) m.st = M_IDLE;
         end
         M_WAIT: begin
            if (hl) m.st = M_HALT;
            else if (start_fall) m.st = M_IDLE;
            else if (step_rise) m.st = M_PULSE;
         end
         M_PULSE: begin
            if (hl) m.st = M_HALT;
            else if (at_limit) begin m.st = M_HALT; m.to = 1'b1; end
            else if (start_fall) m.st = M_IDLE;
            else m.st = M_WAIT;
         end
         default: begin
            if (!m.db[0]) begin m.st = M_IDLE; m.cnt = 0; m.to = 1'b0; end
         end
      endcase
      m.dbp = m.db;
      for (int i = 0; i < 2; i++) begin
         if (m.s2[i] != m.db[i]) begin
            m.run[i] = m.run[i] + 8'd1;
            if (int'(m.run[i]) == DBC) begin
               m.db[i]  = m.s2[i];
               m.run[i] = 8'd0;
            end
         end else begin
            m.run[i] = 8'd0;
         end
      end
      m.s2 = m.s1;
      m.s1 = {raw_step, raw_start};
      return m;
   endfunction

   function automatic longint mdl_out(mdl_t m);
      logic e, r, d;
      e = (m.st == M_RUN) || (m.st == M_PULSE);
      r = e || (m.st == M_WAIT);
      d = (m.st == M_HALT);
      return (longint'({e, r, d, m.to}) << 16) | m.cnt;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         ma = mdl_reset();
         mb = mdl_reset();
      end else begin
         ma = mdl_step(ma, switchStart, switchStep, mode, halt_in, 20, 16);
         mb = mdl_step(mb, switchStart, switchStep, mode, halt_in, 0, 4);
      end
      @(negedge clk);
      chk("model_a", (longint'({en_a, running_a, done_a, timeout_a}) << 16) | longint'(cnt_a),
          mdl_out(ma));
      chk("model_b", (longint'({en_b, running_b, done_b, timeout_b}) << 16) | longint'(cnt_b),
          mdl_out(mb));
   endtask

   typedef struct {
      logic st, sp, md, hl;
      int   n;
      logic e, r, d, t;
      int   cnt;
      int   p;
   } row_t;

   row_t tbl[$];

   function automatic void add(logic st, logic sp, logic md, logic hl, int n,
                               logic e, logic r, logic d, logic t, int cnt, int p);
      row_t rw;
      rw.st = st; rw.sp = sp; rw.md = md; rw.hl = hl; rw.n = n;
      rw.e = e; rw.r = r; rw.d = d; rw.t = t; rw.cnt = cnt; rw.p = p;
      tbl.push_back(rw);
   endfunction

   task automatic run_rows(int lo, int hi);
      int pulses;
      for (int i = lo; i <= hi; i++) begin
         switchStart = tbl[i].st;
         switchStep  = tbl[i].sp;
         mode        = tbl[i].md;
         halt_in     = tbl[i].hl;
         pulses      = 0;
         repeat (tbl[i].n) begin
            tick();
            if (en_a) pulses++;
         end
         $display("row %0d: start=%0b step=%0b mode=%0b halt=%0b n=%0d -> en=%0b done=%0b to=%0b cnt=%0d pulses=%0d",
                  i, tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].hl, tbl[i].n, en_a, done_a,
                  timeout_a, cnt_a, pulses);
         chk($sformatf("row%0d_flags", i), longint'({en_a, running_a, done_a, timeout_a}),
             longint'({tbl[i].e, tbl[i].r, tbl[i].d, tbl[i].t}));
         chk($sformatf("row%0d_count", i), longint'(cnt_a), longint'(tbl[i].cnt));
         chk($sformatf("row%0d_pulses", i), longint'(pulses), longint'(tbl[i].p));
      end
      halt_in = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int first_en;
      int pulses;
      int n;

      //  st sp md hl  n   e  r  d  t  cnt  pulses
      add(1, 0, 0, 0, 10,  1, 1, 0, 0, 10,  10);   // 0  running up to 10
      add(1, 0, 0, 1,  1,  0, 0, 1, 0, 11,   0);   // 1  halt
      add(1, 0, 0, 0,  5,  0, 0, 1, 0, 11,   0);   // 2  stays halted while start high
      add(0, 0, 0, 0,  7,  0, 0, 0, 0,  0,   0);   // 3  start low -> idle, cleared
      add(1, 0, 0, 0, 27,  0, 0, 1, 1, 20,  20);   // 4  run into the limit
      add(0, 0, 0, 0,  7,  0, 0, 0, 0,  0,   0);   // 5  leave halted
      add(1, 0, 1, 0,  7,  0, 1, 0, 0,  0,   0);   // 6  step mode
      add(1, 1, 1, 0, 10,  0, 1, 0, 0,  1,   1);   // 7  press 1
      add(1, 0, 1, 0, 10,  0, 1, 0, 0,  1,   0);
      add(1, 1, 1, 0, 10,  0, 1, 0, 0,  2,   1);   // 9  press 2
      add(1, 0, 1, 0, 10,  0, 1, 0, 0,  2,   0);
      add(1, 1, 1, 0, 10,  0, 1, 0, 0,  3,   1);   // 11 press 3
      add(1, 0, 1, 0, 10,  0, 1, 0, 0,  3,   0);
      add(1, 1, 1, 0, 50,  0, 1, 0, 0,  4,   1);   // 13 long press, one pulse
      add(1, 0, 1, 0, 10,  0, 1, 0, 0,  4,   0);
      add(0, 0, 0, 0,  7,  0, 0, 0, 0,  4,   0);   // 15 pause, count held
      add(1, 0, 0, 0,  7,  1, 1, 0, 0,  4,   1);   // 16 resume free run from 4
      add(0, 0, 0, 0,  7,  0, 0, 0, 0, 11,   6);   // 17 pause again
      add(0, 0, 0, 0,  5,  0, 0, 0, 0, 11,   0);   // 18 held in idle
      add(1, 0, 0, 0,  7,  1, 1, 0, 0, 11,   1);   // 19 resume
      add(1, 0, 0, 0,  3,  1, 1, 0, 0, 14,   3);   // 20 continues from 11
      add(1, 0, 0, 0,  7,  1, 1, 0, 0,  0,   1);   // 21 fresh run after reset
      add(1, 0, 0, 0, 19,  1, 1, 0, 0, 19,  19);   // 22 one short of the limit
      add(1, 0, 0, 1,  1,  0, 0, 1, 0, 20,   0);   // 23 halt + limit together
      add(0, 0, 0, 0,  7,  0, 0, 0, 0,  0,   0);   // 24 back to idle

      ma = mdl_reset();
      mb = mdl_reset();

      // Reset held for three edges
      repeat (3) tick();
      chk("reset_outputs_a", (longint'({en_a, running_a, done_a, timeout_a}) << 16) | longint'(cnt_a), 0);
      chk("reset_outputs_b", (longint'({en_b, running_b, done_b, timeout_b}) << 16) | longint'(cnt_b), 0);

      // Start latency
      rst         = 1'b1;
      switchStart = 1'b1;
      mode        = 1'b0;
      first_en    = 0;
      for (int k = 1; k <= 20 && first_en == 0; k++) begin
         tick();
         if (en_a) first_en = k;
      end
      $display("start: first en after %0d edges", first_en);
      chk("start_latency", longint'(first_en), 7);
      chk("start_running", longint'(running_a), 1);

      run_rows(0, 20);

      // Asynchronous reset in the middle of a run
      #2;
      rst         = 1'b0;
      switchStart = 1'b0;
      #1;
      $display("async reset: en=%0b cnt=%0d", en_a, cnt_a);
      chk("async_reset_en", longint'(en_a), 0);
      chk("async_reset_cnt", longint'(cnt_a), 0);
      chk("async_reset_b", (longint'({en_b, running_b, done_b, timeout_b}) << 16) | longint'(cnt_b), 0);
      tick();
      rst = 1'b1;

      // Start glitch shorter than the debounce window
      pulses      = 0;
      switchStart = 1'b1;
      repeat (3) begin tick(); if (en_a || running_a) pulses++; end
      switchStart = 1'b0;
      repeat (10) begin tick(); if (en_a || running_a) pulses++; end
      $display("glitch: active cycles=%0d", pulses);
      chk("glitch_active", longint'(pulses), 0);

      run_rows(21, 24);

      // Randomised stretches of switch activity
      for (int ph = 0; ph < 250; ph++) begin
         switchStart = ($urandom_range(0, 9) < 7);
         switchStep  = 1'($urandom_range(0, 1));
         mode        = 1'($urandom_range(0, 1));
         n           = int'($urandom_range(1, 14));
         repeat (n) begin
            halt_in = ($urandom_range(0, 29) == 0);
            tick();
         end
         $display("phase %0d: start=%0b step=%0b mode=%0b n=%0d -> en=%0b done=%0b cnt=%0d",
                  ph, switchStart, switchStep, mode, n, en_a, done_a, cnt_a);
      end
      halt_in = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
